// File: rtl/pe_ec_l4_ctrl.sv
// -----------------------------------------------------------------------------
// pe_ec_l4_ctrl
//
// Sequencer for a combinational binarizing PE. For every pooled output
// position (row-major) it fetches one input window, then steps through all
// filters on that window. For each filter it waits PE_LAT settle cycles,
// captures the PE result and offers it on a valid/ready handshake.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous active-high reset
//   start      : begins a pass when sampled high in IDLE
//   abort      : synchronous cancel of the current pass (any non-IDLE state)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse at the end of a completed pass
//   win_req    : window request, held until win_ack
//   win_row    : pooled row of the requested window
//   win_col    : pooled column of the requested window
//   win_ack    : window is applied to the PE (only observed in FETCH)
//   wt_sel     : filter index driving the weight/norm muxes of the PE
//   pe_result  : PE output, one-hot position; any pattern is passed unchanged
//   out_valid  : result valid, held until out_ready
//   out_ready  : result accepted by the sink
//   out_data   : captured PE result
//   out_filt   : filter tag of out_data
//   out_row    : row tag of out_data
//   out_col    : column tag of out_data
// -----------------------------------------------------------------------------
module pe_ec_l4_ctrl #(
    parameter int OUT_H  = 4,
    parameter int OUT_W  = 4,
    parameter int N_FILT = 8,
    parameter int PE_LAT = 1,
    localparam int RW = (OUT_H  > 1) ? $clog2(OUT_H)  : 1,
    localparam int CW = (OUT_W  > 1) ? $clog2(OUT_W)  : 1,
    localparam int FW = (N_FILT > 1) ? $clog2(N_FILT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          win_req,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    input  logic          win_ack,
    output logic [FW-1:0] wt_sel,
    input  logic [3:0]    pe_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_data,
    output logic [FW-1:0] out_filt,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col
);

    // Settle counter width: counts 0 .. PE_LAT-1
    localparam int LW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    localparam logic [RW-1:0] ROW_LAST  = RW'(OUT_H - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(OUT_W - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(N_FILT - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(PE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_COMPUTE = 3'd2,
        S_EMIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [FW-1:0] r_filt;
    logic [LW-1:0] r_lat;

    logic [3:0]    r_out_data;
    logic [RW-1:0] r_out_row;
    logic [CW-1:0] r_out_col;
    logic [FW-1:0] r_out_filt;

    logic          w_filt_last;
    logic          w_pass_last;
    logic          w_lat_last;
    logic          w_abort;

    assign w_filt_last = (r_filt == FILT_LAST);
    assign w_pass_last = w_filt_last && (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_lat_last  = (r_lat == LAT_LAST);
    // Abort is meaningless in IDLE; everywhere else it wins over any handshake
    assign w_abort     = abort && (r_state != S_IDLE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_next = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (win_ack) begin
                        w_state_next = S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (w_lat_last) begin
                        w_state_next = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (w_pass_last) begin
                            w_state_next = S_DONE;
                        end else if (!w_filt_last) begin
                            // Same window, next filter: no refetch needed
                            w_state_next = S_COMPUTE;
                        end else begin
                            w_state_next = S_FETCH;
                        end
                    end
                end
                // start sampled here is deliberately ignored
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (state-only, so async reset clears them immediately)
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        win_req   = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:    ;
            S_FETCH:   begin busy = 1'b1; win_req   = 1'b1; end
            S_COMPUTE: begin busy = 1'b1;                   end
            S_EMIT:    begin busy = 1'b1; out_valid = 1'b1; end
            S_DONE:    begin busy = 1'b1; done      = 1'b1; end
            default:   ;
        endcase
    end

    assign win_row  = r_row;
    assign win_col  = r_col;
    assign wt_sel   = r_filt;
    assign out_data = r_out_data;
    assign out_row  = r_out_row;
    assign out_col  = r_out_col;
    assign out_filt = r_out_filt;

    // -------------------------------------------------------------------------
    // Position / filter counters, settle counter and result capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_filt     <= '0;
            r_lat      <= '0;
            r_out_data <= '0;
            r_out_row  <= '0;
            r_out_col  <= '0;
            r_out_filt <= '0;
        end else if (w_abort) begin
            // Drop everything, including a result still waiting in EMIT
            r_row      <= '0;
            r_col      <= '0;
            r_filt     <= '0;
            r_lat      <= '0;
            r_out_data <= '0;
            r_out_row  <= '0;
            r_out_col  <= '0;
            r_out_filt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row  <= '0;
                        r_col  <= '0;
                        r_filt <= '0;
                        r_lat  <= '0;
                    end
                end
                S_FETCH: begin
                    r_lat <= '0;
                end
                S_COMPUTE: begin
                    if (w_lat_last) begin
                        r_lat      <= '0;
                        r_out_data <= pe_result;
                        r_out_row  <= r_row;
                        r_out_col  <= r_col;
                        r_out_filt <= r_filt;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (!w_filt_last) begin
                            r_filt <= r_filt + 1'b1;
                        end else begin
                            r_filt <= '0;
                            if (r_col == COL_LAST) begin
                                r_col <= '0;
                                // Row wraps on the final position so the
                                // counters are already clear when DONE is hit
                                if (r_row == ROW_LAST) begin
                                    r_row <= '0;
                                end else begin
                                    r_row <= r_row + 1'b1;
                                end
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_ec_l4_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pe_ec_l4_ctrl: a 2x2x2 instance (PE_LAT=1) for the main
// sequencing cases and a 1x1x1 instance (PE_LAT=3) for the degenerate case.
// -----------------------------------------------------------------------------
module tb_pe_ec_l4_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    // Main instance 2x2, 2 filters, PE_LAT=1
    logic       start, abort, win_ack, out_ready;
    logic [3:0] pe_result;
    logic       busy, done, win_req, out_valid;
    logic       win_row, win_col, wt_sel;
    logic [3:0] out_data;
    logic       out_filt, out_row, out_col;

    // Degenerate instance 1x1, 1 filter, PE_LAT=3
    logic       start_d, abort_d, win_ack_d, out_ready_d;
    logic [3:0] pe_result_d;
    logic       busy_d, done_d, win_req_d, out_valid_d;
    logic       win_row_d, win_col_d, wt_sel_d;
    logic [3:0] out_data_d;
    logic       out_filt_d, out_row_d, out_col_d;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_ec_l4_ctrl #(.OUT_H(2), .OUT_W(2), .N_FILT(2), .PE_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .win_req(win_req),
        .win_row(win_row), .win_col(win_col), .win_ack(win_ack),
        .wt_sel(wt_sel), .pe_result(pe_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_filt(out_filt),
        .out_row(out_row), .out_col(out_col)
    );

    pe_ec_l4_ctrl #(.OUT_H(1), .OUT_W(1), .N_FILT(1), .PE_LAT(3)) dut_d (
        .clk(clk), .rst(rst), .start(start_d), .abort(abort_d),
        .busy(busy_d), .done(done_d), .win_req(win_req_d),
        .win_row(win_row_d), .win_col(win_col_d), .win_ack(win_ack_d),
        .wt_sel(wt_sel_d), .pe_result(pe_result_d),
        .out_valid(out_valid_d), .out_ready(out_ready_d),
        .out_data(out_data_d), .out_filt(out_filt_d),
        .out_row(out_row_d), .out_col(out_col_d)
    );

    typedef struct {
        logic [3:0] pe;     // value presented on pe_result for this result
        logic [3:0] data;   // expected out_data
        logic       row;
        logic       col;
        logic       filt;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One pass on the main instance.
    //   bp_at    : result index that sees out_ready low for 5 cycles (-1 none)
    //   ack_dly  : cycles win_ack is withheld on the first fetch
    //   abort_at : result index whose EMIT cycle gets abort (-1 none)
    task automatic run_pass(input int bp_at, input int ack_dly, input int abort_at, input string name);
        int   n = 0, fetches = 0, dones = 0, hold = 0, stall = 0, req_cyc = 0, cyc;
        logic aborted = 1'b0;
        logic holding;
        abort     = 1'b0;
        out_ready = 1'b1;
        win_ack   = (ack_dly == 0);
        pe_result = tbl[0].pe;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (!busy && dones > 0) break;
            holding = 1'b0;
            if (done) dones++;
            if (win_req) begin
                req_cyc++;
                if (stall < ack_dly) begin
                    win_ack = 1'b0;
                    stall++;
                    chk({name, " stall wt_sel"}, 32'(wt_sel), 0);
                    chk({name, " stall out_valid"}, 32'(out_valid), 0);
                end else begin
                    win_ack = 1'b1;
                    fetches++;
                    chk({name, " win pos"}, {win_row, win_col}, {tbl[n].row, tbl[n].col});
                end
            end else begin
                win_ack = 1'b1;
            end
            if (out_valid) begin
                if (n == abort_at) begin
                    abort     = 1'b1;
                    out_ready = 1'b1;
                    aborted   = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    break;
                end
                if (n == bp_at && hold < 5) begin
                    out_ready = 1'b0;
                    hold++;
                    holding   = 1'b1;
                    pe_result = ~tbl[n].pe;
                    chk({name, " held result"}, {out_data, out_row, out_col, out_filt},
                        {tbl[n].data, tbl[n].row, tbl[n].col, tbl[n].filt});
                end else begin
                    out_ready = 1'b1;
                    chk({name, " result"}, {out_data, out_row, out_col, out_filt},
                        {tbl[n].data, tbl[n].row, tbl[n].col, tbl[n].filt});
                    $display("%s: result %0d data=%b row=%0d col=%0d filt=%0d", name, n,
                             out_data, out_row, out_col, out_filt);
                    n++;
                end
            end
            if (!holding) pe_result = tbl[(n < 8) ? n : 7].pe;
            @(negedge clk);
        end
        if (cyc >= 300) chk({name, " cycle budget"}, 32'(cyc), 0);
        if (aborted) begin
            chk({name, " abort status"}, {busy, win_req, out_valid, done}, 0);
            chk({name, " abort sel/pos"}, {wt_sel, win_row, win_col}, 0);
            chk({name, " abort out"}, {out_data, out_row, out_col, out_filt}, 0);
            chk({name, " abort results"}, 32'(n), 32'(abort_at));
            chk({name, " abort fetches"}, 32'(fetches), 3);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done || busy) dones++;
            end
            chk({name, " abort no done"}, 32'(dones), 0);
        end else begin
            chk({name, " results"}, 32'(n), 8);
            chk({name, " fetches"}, 32'(fetches), 4);
            chk({name, " done pulses"}, 32'(dones), 1);
            chk({name, " busy after"}, 32'(busy), 0);
            chk({name, " win_req cycles"}, 32'(req_cyc), 32'(4 + ack_dly));
        end
        $display("%s: %0d results, %0d fetches, %0d done", name, n, fetches, dones);
    endtask

    initial begin
        int f, c, r, d;
        tbl[0] = '{4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{4'b0101, 4'b0101, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        start = 1'b0; abort = 1'b0; win_ack = 1'b1; out_ready = 1'b1; pe_result = 4'b0;
        start_d = 1'b0; abort_d = 1'b0; win_ack_d = 1'b1; out_ready_d = 1'b1; pe_result_d = 4'b1000;

        #1;
        chk("reset status", {busy, done, win_req, out_valid}, 0);
        chk("reset sel/pos", {wt_sel, win_row, win_col}, 0);
        chk("reset out", {out_data, out_row, out_col, out_filt}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle without start", 32'(busy), 0);

        run_pass(-1, 0, -1, "basic");
        run_pass(2, 0, -1, "backpressure");
        run_pass(-1, 3, -1, "fetch stall");
        run_pass(-1, 0, 4, "abort");
        run_pass(-1, 0, -1, "restart");

        // Async reset while computing filter 1 of the first window
        start = 1'b1; out_ready = 1'b1; win_ack = 1'b1; pe_result = tbl[0].pe;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        chk("pre-reset valid", 32'(out_valid), 1);
        @(negedge clk);
        chk("pre-reset compute", {busy, win_req, out_valid, wt_sel}, 4'b1001);
        chk("pre-reset out_data", 32'(out_data), 32'(tbl[0].pe));
        #2 rst = 1'b1;
        #1;
        $display("async reset: busy=%b wt_sel=%b out_data=%b", busy, wt_sel, out_data);
        chk("async rst status", {busy, done, win_req, out_valid}, 0);
        chk("async rst sel", 32'(wt_sel), 0);
        chk("async rst out", {out_data, out_row, out_col, out_filt}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post-reset idle", 32'(busy), 0);
        run_pass(-1, 0, -1, "after reset");

        // Degenerate sizes, start held high throughout (must be ignored)
        f = 0; c = 0; r = 0; d = 0;
        start_d = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if (win_req_d) f++;
            if (busy_d && !win_req_d && !out_valid_d && !done_d) c++;
            if (out_valid_d) begin
                r++;
                chk("degen result", {out_data_d, out_row_d, out_col_d, out_filt_d}, 7'b1000_000);
            end
            if (done_d) begin
                d++;
                @(negedge clk);
                start_d = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("degen busy after", 32'(busy_d), 0);
        @(negedge clk);
        chk("degen stays idle", 32'(busy_d), 0);
        chk("degen fetches", 32'(f), 1);
        chk("degen compute cycles", 32'(c), 3);
        chk("degen results", 32'(r), 1);
        chk("degen done", 32'(d), 1);
        $display("degenerate: fetches=%0d compute=%0d results=%0d done=%0d", f, c, r, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
